// File: rtl/ex_mem_stage_pkg.sv
// ALU opcodes and datapath widths shared by the execute stage.
// Operand widths, opcode encodings and the NOP alias live here.
package alu_pkg;

  localparam int DATA_W  = 8;
  localparam int INSTR_W = 19;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;
  localparam logic [2:0] ALU_NOP = 3'b100;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage.
// master drives ID/EX and observes EX/MEM; slave is the stage.
interface ex_mem_stage_if #(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 19
);

  logic [DATA_W-1:0]  ID_EX_A;
  logic [DATA_W-1:0]  ID_EX_B;
  logic [INSTR_W-1:0] ID_EX_instruction;
  logic               ID_EX_mem_write;
  logic               ID_EX_reg_write;
  logic               ID_EX_alu_use_carry;
  logic               ID_EX_alu_B_mux;
  logic               ID_EX_select_c;
  logic               ID_EX_select_z;
  logic               ID_EX_write_c;
  logic               ID_EX_write_z;
  logic [2:0]         ID_EX_alu_op;
  logic [1:0]         ID_EX_reg_write_mux;

  logic [DATA_W-1:0]  EX_MEM_result;
  logic [DATA_W-1:0]  EX_MEM_B;
  logic [INSTR_W-1:0] EX_MEM_instruction;
  logic               EX_MEM_mem_write;
  logic               EX_MEM_reg_write;
  logic               EX_MEM_cond;
  logic [1:0]         EX_MEM_reg_write_mux;

  modport master (
    output ID_EX_A, ID_EX_B, ID_EX_instruction,
    output ID_EX_mem_write, ID_EX_reg_write,
    output ID_EX_alu_use_carry, ID_EX_alu_B_mux,
    output ID_EX_select_c, ID_EX_select_z,
    output ID_EX_write_c, ID_EX_write_z,
    output ID_EX_alu_op, ID_EX_reg_write_mux,
    input  EX_MEM_result, EX_MEM_B,
    input  EX_MEM_instruction,
    input  EX_MEM_mem_write, EX_MEM_reg_write,
    input  EX_MEM_cond, EX_MEM_reg_write_mux
  );

  modport slave (
    input  ID_EX_A, ID_EX_B, ID_EX_instruction,
    input  ID_EX_mem_write, ID_EX_reg_write,
    input  ID_EX_alu_use_carry, ID_EX_alu_B_mux,
    input  ID_EX_select_c, ID_EX_select_z,
    input  ID_EX_write_c, ID_EX_write_z,
    input  ID_EX_alu_op, ID_EX_reg_write_mux,
    output EX_MEM_result, EX_MEM_B,
    output EX_MEM_instruction,
    output EX_MEM_mem_write, EX_MEM_reg_write,
    output EX_MEM_cond, EX_MEM_reg_write_mux
  );

endinterface

// File: rtl/ex_mem_stage_alu.sv
// Combinational ALU: eight ops, carry/borrow out and zero detect.
// Subtraction reports borrow in carry_out, matching the SUB-with-C chain.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic [2:0]   op,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         zero
);

  logic [W:0] wide;

  always_comb begin
    wide      = '0;
    result    = '0;
    carry_out = 1'b0;
    unique case (op)
      ALU_ADD: begin
        wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        result    = wide[W-1:0];
        carry_out = wide[W];
      end
      ALU_SUB: begin
        // Underflow wraps into bit W, which is exactly the borrow.
        wide = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
        result    = wide[W-1:0];
        carry_out = wide[W];
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_PASS: result = a;
      ALU_XOR:  result = a ^ b;
      ALU_SHL: begin
        result    = {a[W-2:0], 1'b0};
        carry_out = a[W-1];
      end
      ALU_SHR: begin
        result    = {1'b0, a[W-1:1]};
        carry_out = a[0];
      end
      default: result = a;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_mem_stage_ff.sv
// Clearable, enabled register used for the EX/MEM pipeline latch.
// Clear beats enable so a bubble can be forced regardless of d.
module M_S_FF #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage: operand select, ALU, C/Z flags and EX/MEM register.
// Branch condition sees the flags this instruction itself produces.
module ex_mem_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int INSTR_W = alu_pkg::INSTR_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           flush,
  ex_mem_stage_if.slave  bus,
  output logic           flag_c,
  output logic           flag_z
);

  localparam int REG_W = 2*DATA_W + INSTR_W + 5;

  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cin;
  logic              alu_co;
  logic              alu_zero;
  logic              upd;
  logic              c_next;
  logic              z_next;
  logic              cond;
  logic              clr;
  logic [REG_W-1:0]  reg_d;
  logic [REG_W-1:0]  reg_q;

  assign op_b = bus.ID_EX_alu_B_mux
              ? bus.ID_EX_instruction[DATA_W-1:0]
              : bus.ID_EX_B;
  assign alu_cin = bus.ID_EX_alu_use_carry & flag_c;

  alu_core #(.W(DATA_W)) u_alu (
    .a         (bus.ID_EX_A),
    .b         (op_b),
    .cin       (alu_cin),
    .op        (bus.ID_EX_alu_op),
    .result    (alu_res),
    .carry_out (alu_co),
    .zero      (alu_zero)
  );

  assign upd    = ~stall & ~flush;
  assign c_next = (upd & bus.ID_EX_write_c) ? alu_co   : flag_c;
  assign z_next = (upd & bus.ID_EX_write_z) ? alu_zero : flag_z;
  assign cond   = (bus.ID_EX_select_c & c_next)
                | (bus.ID_EX_select_z & z_next);

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      flag_c <= c_next;
      flag_z <= z_next;
    end
  end

  // Stall outranks flush, so a flush arriving under stall is dropped.
  assign clr = reset | (flush & ~stall);

  assign reg_d = {
    alu_res,
    bus.ID_EX_B,
    bus.ID_EX_instruction,
    bus.ID_EX_mem_write,
    bus.ID_EX_reg_write,
    cond,
    bus.ID_EX_reg_write_mux
  };

  M_S_FF #(.W(REG_W)) u_ex_mem (
    .clk (clk),
    .clr (clr),
    .en  (~stall),
    .d   (reg_d),
    .q   (reg_q)
  );

  assign {
    bus.EX_MEM_result,
    bus.EX_MEM_B,
    bus.EX_MEM_instruction,
    bus.EX_MEM_mem_write,
    bus.EX_MEM_reg_write,
    bus.EX_MEM_cond,
    bus.EX_MEM_reg_write_mux
  } = reg_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Vector table plus scoreboard for ex_mem_stage.
// Expected ALU/flag values are hand-derived constants in the table.
module tb_ex_mem_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic stall;
  logic flush;
  logic flag_c;
  logic flag_z;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk    (clk),
    .reset  (reset),
    .stall  (stall),
    .flush  (flush),
    .bus    (bus),
    .flag_c (flag_c),
    .flag_z (flag_z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [18:0] instr;
    logic        uc, bm, sc, sz, wc, wz, mw, rw;
    logic [1:0]  rwm;
    logic        st, fl;
    logic [7:0]  er;
    logic        ec, ez, ecd;
  } vec_t;

  typedef struct {
    logic [7:0]  res;
    logic [7:0]  b;
    logic [18:0] instr;
    logic        mw, rw, cond;
    logic [1:0]  rwm;
    logic        c, z;
  } exp_t;

  vec_t vecs[20];
  exp_t sb[$];
  exp_t last;
  int   tests = 0;
  int   fails = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.ID_EX_alu_op        = v.op;
    bus.ID_EX_A             = v.a;
    bus.ID_EX_B             = v.b;
    bus.ID_EX_instruction   = v.instr;
    bus.ID_EX_alu_use_carry = v.uc;
    bus.ID_EX_alu_B_mux     = v.bm;
    bus.ID_EX_select_c      = v.sc;
    bus.ID_EX_select_z      = v.sz;
    bus.ID_EX_write_c       = v.wc;
    bus.ID_EX_write_z       = v.wz;
    bus.ID_EX_mem_write     = v.mw;
    bus.ID_EX_reg_write     = v.rw;
    bus.ID_EX_reg_write_mux = v.rwm;
    stall                   = v.st;
    flush                   = v.fl;
  endtask

  // Pass-through fields come from the row, the held value, or zero.
  function automatic exp_t predict(vec_t v, exp_t prev);
    exp_t e;
    if (v.st)
      e = prev;
    else if (v.fl)
      e = '{8'h00, 8'h00, 19'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    else
      e = '{v.er, v.b, v.instr, v.mw, v.rw, v.ecd, v.rwm, 1'b0, 1'b0};
    if (!v.st) begin
      e.res  = v.er;
      e.cond = v.ecd;
    end
    e.c = v.ec;
    e.z = v.ez;
    return e;
  endfunction

  task automatic step_and_check(string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".result"}, {24'h0, bus.EX_MEM_result}, {24'h0, e.res});
      check({tag, ".B"}, {24'h0, bus.EX_MEM_B}, {24'h0, e.b});
      check({tag, ".instr"}, {13'h0, bus.EX_MEM_instruction}, {13'h0, e.instr});
      check({tag, ".mem_write"}, {31'h0, bus.EX_MEM_mem_write}, {31'h0, e.mw});
      check({tag, ".reg_write"}, {31'h0, bus.EX_MEM_reg_write}, {31'h0, e.rw});
      check({tag, ".cond"}, {31'h0, bus.EX_MEM_cond}, {31'h0, e.cond});
      check({tag, ".rwm"}, {30'h0, bus.EX_MEM_reg_write_mux}, {30'h0, e.rwm});
      check({tag, ".flag_c"}, {31'h0, flag_c}, {31'h0, e.c});
      check({tag, ".flag_z"}, {31'h0, flag_z}, {31'h0, e.z});
      last = e;
    end
  endtask

  initial begin
    vec_t rv;
    exp_t zero_e;

    //           op      a      b      instr      uc bm sc sz wc wz mw rw rwm st fl er     ec ez cd
    vecs[0]  = '{ALU_ADD, 8'hF0, 8'h20, 19'h11111, 0, 0, 0, 0, 1, 1, 1, 0, 2, 0, 0, 8'h10, 1, 0, 0};
    vecs[1]  = '{ALU_ADD, 8'h01, 8'h02, 19'h22222, 1, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0, 8'h04, 0, 0, 0};
    vecs[2]  = '{ALU_SUB, 8'h55, 8'h55, 19'h33333, 0, 0, 0, 1, 0, 1, 0, 1, 3, 0, 0, 8'h00, 0, 1, 1};
    vecs[3]  = '{ALU_OR,  8'hF0, 8'h33, 19'h5A50F, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 8'hFF, 0, 0, 0};
    vecs[4]  = '{ALU_SUB, 8'h10, 8'h20, 19'h44444, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0, 8'hF0, 1, 0, 1};
    vecs[5]  = '{ALU_SUB, 8'h05, 8'h04, 19'h55555, 1, 0, 0, 1, 1, 1, 1, 0, 2, 0, 0, 8'h00, 0, 1, 1};
    vecs[6]  = '{ALU_XOR, 8'hAA, 8'hFF, 19'h66666, 0, 0, 0, 0, 0, 1, 0, 1, 3, 0, 0, 8'h55, 0, 0, 0};
    vecs[7]  = '{ALU_SHL, 8'h81, 8'h00, 19'h77777, 0, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 8'h02, 1, 0, 1};
    vecs[8]  = '{ALU_SHR, 8'h81, 8'h00, 19'h01010, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 8'h40, 1, 0, 0};
    vecs[9]  = '{ALU_AND, 8'h0F, 8'hF0, 19'h02020, 0, 0, 0, 1, 1, 1, 1, 0, 2, 0, 0, 8'h00, 0, 1, 1};
    vecs[10] = '{ALU_NOP, 8'h00, 8'h77, 19'h03030, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 1, 1};
    vecs[11] = '{ALU_ADD, 8'hFF, 8'h01, 19'h04040, 0, 0, 1, 0, 1, 1, 1, 1, 3, 0, 0, 8'h00, 1, 1, 1};
    vecs[12] = '{ALU_AND, 8'h0F, 8'hF0, 19'h05050, 0, 0, 0, 0, 1, 1, 0, 1, 2, 0, 0, 8'h00, 0, 1, 0};
    vecs[13] = '{ALU_ADD, 8'hF0, 8'h20, 19'h06060, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 0, 8'h00, 0, 1, 0};
    vecs[14] = vecs[13];
    vecs[15] = vecs[13];
    vecs[16] = '{ALU_ADD, 8'hF0, 8'h20, 19'h06060, 0, 0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 8'h10, 1, 0, 1};
    vecs[17] = '{ALU_ADD, 8'hFF, 8'h01, 19'h07070, 0, 0, 1, 0, 1, 1, 1, 1, 3, 0, 1, 8'h00, 1, 0, 0};
    vecs[18] = '{ALU_ADD, 8'h00, 8'h00, 19'h08080, 0, 0, 1, 1, 1, 1, 1, 1, 3, 1, 1, 8'h00, 1, 0, 0};
    vecs[19] = '{ALU_ADD, 8'h00, 8'h00, 19'h09090, 1, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0, 8'h01, 0, 0, 0};

    zero_e = '{8'h00, 8'h00, 19'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

    // Reset with busy inputs clears everything.
    @(negedge clk);
    drive(vecs[11]);
    reset = 1'b1;
    sb.push_back(zero_e);
    step_and_check("reset");
    last = zero_e;

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i]);
      sb.push_back(predict(vecs[i], last));
      step_and_check($sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Reset while stalled: reset wins, state cleared.
    rv = vecs[16];
    rv.st = 1'b1;
    drive(rv);
    reset = 1'b1;
    sb.push_back(zero_e);
    step_and_check("reset_stall");
    last = zero_e;

    // First instruction after reset computes with cleared carry.
    @(negedge clk);
    reset = 1'b0;
    rv = vecs[1];
    rv.er = 8'h03;
    rv.ec = 1'b0;
    rv.ez = 1'b0;
    rv.ecd = 1'b0;
    drive(rv);
    sb.push_back(predict(rv, last));
    step_and_check("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
